uart_rx: RTL and testbench

Asynchronous serial receiver: 8N1 frames, LSB first, fixed baud rate set by parameter. It synchronises the `rx` pin into `sys_clk`, finds the start bit and samples each bit at mid-bit. Each received byte comes out on a parallel bus with a one-cycle valid strobe. It is the receive-side counterpart of the team's `uart_tx`: same parameters, same bit order, same byte/flag handshake style, so a `uart_tx` output pin can be looped straight into `rx`.

---
 rtl/uart_rx.sv | 187 ++++++++++++++++++
 tb/tb_uart_rx.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous serial receiver, LSB first, mid-bit sampling.
// Optional feature macro: UART_RX_FRAME_ERR_EN
//   defined     -> a low stop bit pulses frame_err and suppresses po_flag/po_data
//   not defined -> stop-bit value ignored, frame_err tied low
module uart_rx #(
    parameter int unsigned UART_BPS = 9600,
    parameter int unsigned CLK_FREQ = 50_000_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       rx,
    output logic [7:0] po_data,
    output logic       po_flag,
    output logic       frame_err
);

    localparam int unsigned BAUD_CNT_MAX  = CLK_FREQ / UART_BPS;
    localparam int unsigned BAUD_CNT_HALF = BAUD_CNT_MAX / 2;
    localparam int unsigned CNT_W         = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_rx_s1;
    logic             r_rx_s2;
    logic             r_rx_s3;
    logic [CNT_W-1:0] r_baud_cnt;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift_reg;
    logic [7:0]       r_po_data;
    logic             r_po_flag;
    logic             w_fall;
    logic             w_strike;
    logic             w_load;
    logic             w_shift;
    logic             w_bit_clr;
    logic             w_bit_inc;
`ifdef UART_RX_FRAME_ERR_EN
    logic             r_frame_err;
    logic             w_ferr;
`endif

    assign w_fall   = r_rx_s3 & ~r_rx_s2;
    assign w_strike = (r_baud_cnt == CNT_W'(BAUD_CNT_HALF));

    // Two-flop synchroniser plus one delay flop for falling-edge detection
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
            r_rx_s3 <= 1'b1;
        end else begin
            r_rx_s1 <= rx;
            r_rx_s2 <= r_rx_s1;
            r_rx_s3 <= r_rx_s2;
        end
    end

    // FSM state register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_bit_clr    = 1'b0;
        w_bit_inc    = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
        w_ferr       = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (w_fall) begin
                    w_state_next = START;
                end
            end
            START: begin
                if (w_strike) begin
                    if (!r_rx_s2) begin
                        w_state_next = DATA;
                        w_bit_clr    = 1'b1;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            DATA: begin
                if (w_strike) begin
                    w_shift = 1'b1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_next = STOP;
                    end else begin
                        w_bit_inc = 1'b1;
                    end
                end
            end
            STOP: begin
                if (w_strike) begin
                    w_state_next = IDLE;
`ifdef UART_RX_FRAME_ERR_EN
                    if (r_rx_s2) begin
                        w_load = 1'b1;
                    end else begin
                        w_ferr = 1'b1;
                    end
`else
                    w_load = 1'b1;
`endif
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Baud counter: held at 0 in IDLE (covers the edge-detect cycle), free-wraps otherwise
    always_ff @(posedge sys_clk) begin
        if (sys_rst || r_state == IDLE) begin
            r_baud_cnt <= '0;
        end else if (r_baud_cnt == CNT_W'(BAUD_CNT_MAX - 1)) begin
            r_baud_cnt <= '0;
        end else begin
            r_baud_cnt <= r_baud_cnt + CNT_W'(1);
        end
    end

    // Bit counter and LSB-first shift register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_bit_cnt   <= 3'd0;
            r_shift_reg <= 8'h00;
        end else begin
            if (w_bit_clr) begin
                r_bit_cnt <= 3'd0;
            end else if (w_bit_inc) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_shift) begin
                r_shift_reg <= {r_rx_s2, r_shift_reg[7:1]};
            end
        end
    end

    // Registered byte output and one-cycle strobe
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_po_data <= 8'h00;
            r_po_flag <= 1'b0;
        end else begin
            r_po_flag <= w_load;
            if (w_load) begin
                r_po_data <= r_shift_reg;
            end
        end
    end

    assign po_data = r_po_data;
    assign po_flag = r_po_flag;

`ifdef UART_RX_FRAME_ERR_EN
    // Registered one-cycle framing-error strobe
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_ferr;
        end
    end

    assign frame_err = r_frame_err;
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx with a scaled baud (16 clocks per bit).
module tb_uart_rx;

    localparam int unsigned BPS  = 10;
    localparam int unsigned FREQ = 160;
    localparam int unsigned BIT  = 16;                       // FREQ / BPS
    localparam int unsigned HALF = 8;                        // BIT / 2
    localparam int unsigned LAT  = 3 + 9 * BIT + HALF + 1;   // pin drive to po_flag = 156

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       rx      = 1'b1;
    logic [7:0] po_data;
    logic       po_flag;
    logic       frame_err;

    uart_rx #(.UART_BPS(BPS), .CLK_FREQ(FREQ)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .rx        (rx),
        .po_data   (po_data),
        .po_flag   (po_flag),
        .frame_err (frame_err)
    );

    always #5 sys_clk = ~sys_clk;

    int unsigned cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // Output monitor sampled on the falling edge
    logic [7:0]  rxq[$];
    int unsigned fcyc[$];
    int unsigned n_flag = 0;
    int unsigned n_err = 0;
    int unsigned n_both = 0;
    int unsigned n_data_chg = 0;
    logic [7:0]  prev_data = 8'h00;

    always @(negedge sys_clk) begin
        if (po_flag === 1'b1) begin
            n_flag++;
            rxq.push_back(po_data);
            fcyc.push_back(cyc);
        end
        if (frame_err === 1'b1) n_err++;
        if (po_flag === 1'b1 && frame_err === 1'b1) n_both++;
        if (!sys_rst && po_data !== prev_data && po_flag !== 1'b1) n_data_chg++;
        prev_data = po_data;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        tick(BIT);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    int unsigned t0;
    int unsigned bf;
    int unsigned be;
    logic [7:0]  bytes [8];

    initial begin
        // Reset state
        tick(3);
        chk("rst_po_data", 32'(po_data), 32'h00);
        chk("rst_po_flag", 32'(po_flag), 32'h0);
        chk("rst_frame_err", 32'(frame_err), 32'h0);
        sys_rst = 1'b0;
        tick(5);

        // Single byte 0x55 with latency
        bf = n_flag;
        t0 = cyc;
        send_frame(8'h55, 1'b1);
        tick(10);
        chk("b55_count", 32'(n_flag - bf), 32'd1);
        chk("b55_data", 32'(rxq[bf]), 32'h55);
        chk("b55_latency", 32'(fcyc[bf] - t0), 32'(LAT));

        // Back-to-back 0xA5 then 0x3C
        bf = n_flag;
        t0 = cyc;
        send_frame(8'hA5, 1'b1);
        send_frame(8'h3C, 1'b1);
        tick(10);
        chk("b2b_count", 32'(n_flag - bf), 32'd2);
        chk("b2b_data0", 32'(rxq[bf]), 32'hA5);
        chk("b2b_data1", 32'(rxq[bf+1]), 32'h3C);
        chk("b2b_first_lat", 32'(fcyc[bf] - t0), 32'(LAT));
        chk("b2b_spacing", 32'(fcyc[bf+1] - fcyc[bf]), 32'(10 * BIT));

        // Short low glitch is rejected, then a real frame is received
        bf = n_flag;
        be = n_err;
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(40);
        chk("glitch_no_flag", 32'(n_flag - bf), 32'd0);
        chk("glitch_no_err", 32'(n_err - be), 32'd0);
        send_frame(8'h96, 1'b1);
        tick(10);
        chk("post_glitch_count", 32'(n_flag - bf), 32'd1);
        chk("post_glitch_data", 32'(rxq[bf]), 32'h96);

        // Stop bit forced low on 0x81
        bf = n_flag;
        be = n_err;
        send_frame(8'h81, 1'b0);
        rx = 1'b1;
        tick(20);
`ifdef UART_RX_FRAME_ERR_EN
        chk("ferr_pulse", 32'(n_err - be), 32'd1);
        chk("ferr_no_flag", 32'(n_flag - bf), 32'd0);
        chk("ferr_data_kept", 32'(po_data), 32'h96);
`else
        chk("nostop_flag", 32'(n_flag - bf), 32'd1);
        chk("nostop_data", 32'(rxq[bf]), 32'h81);
        chk("nostop_no_err", 32'(n_err - be), 32'd0);
`endif

        // Reset during data bit 4 of 0xF0, then 0x0F
        bf = n_flag;
        be = n_err;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        rx = 1'b1;
        tick(HALF);
        sys_rst = 1'b1;
        tick(2);
        chk("midrst_po_data", 32'(po_data), 32'h00);
        chk("midrst_po_flag", 32'(po_flag), 32'h0);
        chk("midrst_frame_err", 32'(frame_err), 32'h0);
        tick(BIT);
        sys_rst = 1'b0;
        tick(20);
        send_frame(8'h0F, 1'b1);
        tick(10);
        chk("midrst_count", 32'(n_flag - bf), 32'd1);
        chk("midrst_data", 32'(rxq[bf]), 32'h0F);
        chk("midrst_no_err", 32'(n_err - be), 32'd0);

        // Loopback-style stream of random bytes, including extremes
        bytes[0] = 8'h00;
        bytes[1] = 8'hFF;
        for (int i = 2; i < 8; i++) bytes[i] = 8'($urandom_range(0, 255));
        bf = n_flag;
        be = n_err;
        for (int i = 0; i < 8; i++) send_frame(bytes[i], 1'b1);
        tick(10);
        chk("stream_count", 32'(n_flag - bf), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("stream_byte%0d", i), 32'(rxq[bf+i]), 32'(bytes[i]));
        end
        chk("stream_no_err", 32'(n_err - be), 32'd0);

        // Global invariants
        chk("flag_err_overlap", 32'(n_both), 32'd0);
        chk("data_change_without_flag", 32'(n_data_chg), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
